// File: rtl/brightness_keys_if.sv
// Pushbutton-side and brightness-feedback signals of the brightness key front end.
interface brightness_keys_if;
    logic       key_up_n;
    logic       key_dn_n;
    logic [3:0] level_in;
    logic       inc;
    logic       dec;
    logic [6:0] hex_out;

    modport master (output key_up_n, key_dn_n, level_in, input inc, dec, hex_out);
    modport slave  (input key_up_n, key_dn_n, level_in, output inc, dec, hex_out);
endinterface

// File: rtl/brightness_keys.sv
// Debounced up/down keys to single-cycle inc/dec pulses with auto-repeat, plus level on a 7-seg digit.
// state   | meaning
// IDLE    | no key accepted as held
// UP_HOLD | up held alone, repeating inc
// DN_HOLD | down held alone, repeating dec
// LOCK    | both keys seen pressed, silent until both released
module brightness_keys #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic              clk,
    input  logic              rst,
    brightness_keys_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UP_HOLD = 2'd1,
        DN_HOLD = 2'd2,
        LOCK    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_TC    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] REP_DLY   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RATE  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] REP_ONE   = CNT_W'(1);

    // bit 0 = up key, bit 1 = down key; all key levels are active-low
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic [6:0]       hex_q, hex_d;

    logic             up_p, dn_p;
    logic             fire_up, fire_dn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            for (int k = 0; k < 2; k++) deb_cnt_q[k] <= '0;
            state_q  <= IDLE;
            rep_q    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            hex_q    <= 7'h7F;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            state_q  <= state_d;
            rep_q    <= rep_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            hex_q    <= hex_d;
        end
    end

    // a change is accepted on the DEBOUNCE_CYC-th consecutive differing cycle
    always_comb begin
        sync1_d  = {bus.key_dn_n, bus.key_up_n};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int k = 0; k < 2; k++) begin
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (deb_cnt_q[k] == DEB_TC) stable_d[k] = sync2_q[k];
                else                        deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
            end
        end
    end

    assign up_p = ~stable_q[0];
    assign dn_p = ~stable_q[1];

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        fire_up = 1'b0;
        fire_dn = 1'b0;
        case (state_q)
            IDLE: begin
                rep_d = '0;
                if (up_p && dn_p) begin
                    state_d = LOCK;
                end else if (up_p) begin
                    state_d = UP_HOLD;
                    fire_up = 1'b1;
                    rep_d   = REP_DLY;
                end else if (dn_p) begin
                    state_d = DN_HOLD;
                    fire_dn = 1'b1;
                    rep_d   = REP_DLY;
                end
            end
            // release is checked first so a repeat expiring on release is dropped
            UP_HOLD: begin
                if (!up_p) begin
                    state_d = IDLE;
                end else if (dn_p) begin
                    state_d = LOCK;
                end else if (rep_q == REP_ONE) begin
                    fire_up = 1'b1;
                    rep_d   = REP_RATE;
                end else begin
                    rep_d = rep_q - 1'b1;
                end
            end
            DN_HOLD: begin
                if (!dn_p) begin
                    state_d = IDLE;
                end else if (up_p) begin
                    state_d = LOCK;
                end else if (rep_q == REP_ONE) begin
                    fire_dn = 1'b1;
                    rep_d   = REP_RATE;
                end else begin
                    rep_d = rep_q - 1'b1;
                end
            end
            LOCK: begin
                rep_d = '0;
                if (!up_p && !dn_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // saturation masks only the pulse; the FSM keeps its timing
    assign inc_d = fire_up && (bus.level_in != 4'hF);
    assign dec_d = fire_dn && (bus.level_in != 4'h0);

    always_comb begin
        hex_d = 7'h7F;
        case (bus.level_in)
            4'h0: hex_d = 7'h40;
            4'h1: hex_d = 7'h79;
            4'h2: hex_d = 7'h24;
            4'h3: hex_d = 7'h30;
            4'h4: hex_d = 7'h19;
            4'h5: hex_d = 7'h12;
            4'h6: hex_d = 7'h02;
            4'h7: hex_d = 7'h78;
            4'h8: hex_d = 7'h00;
            4'h9: hex_d = 7'h10;
            4'hA: hex_d = 7'h08;
            4'hB: hex_d = 7'h03;
            4'hC: hex_d = 7'h46;
            4'hD: hex_d = 7'h21;
            4'hE: hex_d = 7'h06;
            4'hF: hex_d = 7'h0E;
            default: hex_d = 7'h7F;
        endcase
    end

    assign bus.inc     = inc_q;
    assign bus.dec     = dec_q;
    assign bus.hex_out = hex_q;

endmodule
